// File: rtl/dac_playback_ctrl.sv
// Playback scheduler between the sample FIFO and the DAC path: prefill to half, then one read
// every 2^SAMPLE_RATE clocks, with underrun detection, sample hold and watermark re-arm.
module dac_playback_ctrl #(
    parameter int unsigned DATAWIDTH   = 14,
    parameter int unsigned SAMPLE_RATE = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable,
    input  logic                 clr_count,
    input  logic                 fifo_empty,
    input  logic                 fifo_above_half,
    input  logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_en,
    output logic [DATAWIDTH-1:0] sample_out,
    output logic                 sample_valid,
    output logic                 playing,
    output logic                 underrun_pulse,
    output logic [CNT_WIDTH-1:0] underrun_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefill  = 2'd1,
        StRun      = 2'd2,
        StUnderrun = 2'd3
    } state_e;

    localparam logic [DATAWIDTH-1:0] Midscale = {1'b1, {(DATAWIDTH-1){1'b0}}};

    state_e                 state_q, state_d;
    logic [SAMPLE_RATE-1:0] phase_q, phase_d;
    logic                   rd_en_d_q;
    logic                   underrun_ev;
    logic [CNT_WIDTH-1:0]   count_d;
    logic [DATAWIDTH-1:0]   sample_d;
    logic                   valid_d;

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = '0;
        underrun_ev = 1'b0;
        rd_en       = (state_q == StRun) && (phase_q == '0) && !fifo_empty && enable;

        // Dropping enable returns to idle from anywhere, ahead of every other transition.
        if (state_q != StIdle && !enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:     if (enable) state_d = StPrefill;
                StPrefill:  if (fifo_above_half) state_d = StRun;
                StRun: begin
                    if (phase_q == '0 && fifo_empty) begin
                        state_d     = StUnderrun;
                        underrun_ev = 1'b1;
                    end
                end
                StUnderrun: if (fifo_above_half) state_d = StRun;
                default:    state_d = StIdle;
            endcase
        end

        // Phase only advances while staying in RUN, so every RUN entry starts at phase 0.
        if (state_q == StRun && state_d == StRun) begin
            phase_d = phase_q + 1'b1;
        end

        count_d = underrun_count;
        if (clr_count) begin
            count_d = '0;
        end else if (underrun_ev && underrun_count != '1) begin
            count_d = underrun_count + 1'b1;
        end

        sample_d = sample_out;
        valid_d  = 1'b0;
        if (!enable && (state_q != StIdle || rd_en_d_q)) begin
            sample_d = Midscale;
        end else if (rd_en_d_q) begin
            sample_d = rd_data;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            rd_en_d_q      <= 1'b0;
            sample_out     <= Midscale;
            sample_valid   <= 1'b0;
            playing        <= 1'b0;
            underrun_pulse <= 1'b0;
            underrun_count <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            rd_en_d_q      <= rd_en;
            sample_out     <= sample_d;
            sample_valid   <= valid_d;
            playing        <= (state_d == StRun);
            underrun_pulse <= underrun_ev;
            underrun_count <= count_d;
        end
    end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Bench for dac_playback_ctrl: FIFO model, cycle-level reference model and an ordered
// scoreboard of accepted samples, driven by directed and randomized traffic.
module tb_dac_playback_ctrl;

    localparam int unsigned DW = 14;
    localparam int unsigned SR = 4;
    localparam int unsigned CW = 8;
    localparam int PERIOD = 1 << SR;
    localparam int MID    = 1 << (DW - 1);
    localparam int MAXC   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic clr_count = 1'b0;
    logic fifo_auto = 1'b0;
    logic f_empty = 1'b1;
    logic f_half = 1'b0;
    logic fifo_empty, fifo_above_half;
    logic [DW-1:0] rd_data = '0;
    logic rd_en, sample_valid, playing, underrun_pulse;
    logic [DW-1:0] sample_out;
    logic [CW-1:0] underrun_count;
    logic [1:0]    state;

    logic          push_req = 1'b0;
    logic [DW-1:0] push_val = '0;
    int            prod_pct = 0;
    logic          probe = 1'b0;
    int            probe_kind = 0;

    logic [DW-1:0] fifo_q[$];
    int            fifo_n = 0;
    logic [DW-1:0] exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: m_* is the state after the last edge, n_* the state after the next one.
    int m_state = 0, m_t = 0, m_sample = MID, m_ucnt = 0;
    bit m_valid = 0, m_upulse = 0, m_playing = 0, m_pend = 0;
    int n_state = 0, n_t = 0, n_sample = MID, n_ucnt = 0;
    bit n_valid = 0, n_upulse = 0, n_playing = 0, n_rd = 0;
    bit mdl_ph0, mdl_uev;

    always #5 clk = ~clk;

    assign fifo_empty      = fifo_auto ? (fifo_n == 0) : f_empty;
    assign fifo_above_half = fifo_auto ? (fifo_n >= 8) : f_half;

    dac_playback_ctrl #(
        .DATAWIDTH  (DW),
        .SAMPLE_RATE(SR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .enable         (enable),
        .clr_count      (clr_count),
        .fifo_empty     (fifo_empty),
        .fifo_above_half(fifo_above_half),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .playing        (playing),
        .underrun_pulse (underrun_pulse),
        .underrun_count (underrun_count),
        .state          (state)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model commit and FIFO behaviour at the clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_t <= 0; m_sample <= MID; m_ucnt <= 0;
            m_valid <= 0; m_upulse <= 0; m_playing <= 0; m_pend <= 0;
        end else begin
            m_state <= n_state; m_t <= n_t; m_sample <= n_sample; m_ucnt <= n_ucnt;
            m_valid <= n_valid; m_upulse <= n_upulse; m_playing <= n_playing; m_pend <= n_rd;
            if (n_rd) begin
                if (fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
                else rd_data <= DW'($urandom);
            end
            if (push_req) fifo_q.push_back(push_val);
            else if (fifo_q.size() < 16 && int'($urandom_range(0, 99)) < prod_pct)
                fifo_q.push_back(DW'($urandom));
            fifo_n <= fifo_q.size();
        end
    end

    // Monitor: compares DUT to the model, pops the scoreboard, then advances the model.
    always @(negedge clk or posedge probe) begin
        if (probe) begin
            if (probe_kind == 0) begin
                chk("rst_state", int'(state), 0);
                chk("rst_rd_en", int'(rd_en), 0);
                chk("rst_sample_out", int'(sample_out), MID);
                chk("rst_sample_valid", int'(sample_valid), 0);
                chk("rst_playing", int'(playing), 0);
                chk("rst_underrun_pulse", int'(underrun_pulse), 0);
                chk("rst_underrun_count", int'(underrun_count), 0);
            end else begin
                chk("sb_drained", exp_q.size(), 0);
            end
        end else begin
            chk("state", int'(state), m_state);
            chk("playing", int'(playing), int'(m_playing));
            chk("sample_out", int'(sample_out), m_sample);
            chk("sample_valid", int'(sample_valid), int'(m_valid));
            chk("underrun_pulse", int'(underrun_pulse), int'(m_upulse));
            chk("underrun_count", int'(underrun_count), m_ucnt);
            if (sample_valid) begin
                chk("sb_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_data", int'(sample_out), int'(exp_q.pop_front()));
            end

            mdl_ph0 = (m_t % PERIOD) == 0;
            n_rd    = (m_state == 2) && mdl_ph0 && !fifo_empty && enable;
            chk("rd_en", int'(rd_en), int'(n_rd));
            mdl_uev = (m_state == 2) && mdl_ph0 && fifo_empty && enable;

            if (m_state != 0 && !enable) n_state = 0;
            else if (m_state == 0) n_state = enable ? 1 : 0;
            else if (m_state == 1) n_state = fifo_above_half ? 2 : 1;
            else if (m_state == 2) n_state = mdl_uev ? 3 : 2;
            else n_state = fifo_above_half ? 2 : 3;

            n_t       = (m_state == 2 && n_state == 2) ? m_t + 1 : 0;
            n_upulse  = mdl_uev;
            n_playing = (n_state == 2);
            if (clr_count) n_ucnt = 0;
            else if (mdl_uev && m_ucnt < MAXC) n_ucnt = m_ucnt + 1;
            else n_ucnt = m_ucnt;

            n_valid  = 0;
            n_sample = m_sample;
            if (!enable && (m_state != 0 || m_pend)) begin
                n_sample = MID;
            end else if (m_pend) begin
                n_sample = int'(rd_data);
                n_valid  = 1;
                exp_q.push_back(rd_data);
            end
        end
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Preload 0x0001..0x0008 then 0x0123 while idle.
        for (int i = 1; i <= 8; i++) begin
            push_val = DW'(i);
            push_req = 1'b1;
            tick();
        end
        push_val = 14'h0123;
        tick();
        push_req = 1'b0;

        f_empty = 1'b0;
        enable  = 1'b1;
        repeat (10) tick();
        f_half = 1'b1;
        tick();
        f_half = 1'b0;
        repeat (9 * PERIOD) tick();

        // Empty at the next phase 0: underrun, hold 0x0123, then re-arm.
        f_empty = 1'b1;
        repeat (30) tick();
        f_empty = 1'b0;
        f_half  = 1'b1;
        tick();
        f_half = 1'b0;
        repeat (20) tick();

        // Drop enable the cycle after a read so the returning data is discarded.
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!n_rd && k < 3 * PERIOD);
        tick();
        enable = 1'b0;
        repeat (4) tick();

        // Drop enable in the first RUN cycle, where a read would otherwise issue.
        enable = 1'b1;
        f_half = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        f_half = 1'b0;
        repeat (4) tick();

        // Back-to-back underruns to saturate the counter, then clear on an underrun edge.
        enable  = 1'b1;
        f_empty = 1'b1;
        f_half  = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 301; i++) begin
            f_half    = 1'b0;
            clr_count = (i == 300);
            tick();
            f_half    = 1'b1;
            clr_count = 1'b0;
            tick();
        end

        // Randomized producer rate, enable drops and counter clears.
        f_half    = 1'b0;
        fifo_auto = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                case ((i / 500) % 4)
                    0: prod_pct = 4;
                    1: prod_pct = 12;
                    2: prod_pct = 6;
                    default: prod_pct = 40;
                endcase
            end
            if (enable) enable = ($urandom_range(0, 399) != 0);
            else enable = ($urandom_range(0, 4) == 0);
            clr_count = ($urandom_range(0, 149) == 0);
            tick();
        end

        // Asynchronous reset mid-period in RUN.
        prod_pct  = 0;
        fifo_auto = 1'b0;
        clr_count = 1'b0;
        enable    = 1'b1;
        f_empty   = 1'b0;
        f_half    = 1'b1;
        repeat (3) tick();
        f_half = 1'b0;
        repeat (5) tick();
        rst    = 1'b1;
        enable = 1'b0;
        #1 probe_kind = 0;
        probe = 1'b1;
        #1 probe = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (3) tick();

        #1 probe_kind = 1;
        probe = 1'b1;
        #1 probe = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_playback_ctrl.md
# dac_playback_ctrl

Playback scheduler for the upsampling DAC path. It sits between the sample FIFO and the interpolation/DAC driver chain. It holds off playback until the FIFO has prefilled to half, then issues exactly one FIFO read every 2^SAMPLE_RATE clocks. It registers each sample for downstream and detects and counts underruns. On underrun it holds the last sample and re-arms on the half-full watermark.

## Interface
- DATAWIDTH, 14, sample width (equals FIFO_WIDTH)
- SAMPLE_RATE, 4, log2 of clocks per FIFO read (read period = 2^SAMPLE_RATE)
- CNT_WIDTH, 8, width of underrun counter
- clk_in  in  1  single system clock, all logic on rising edge
- rst_in  in  1  asynchronous, active-high reset
- enable  in  1  playback request; level sensitive
- clr_count  in  1  synchronous clear of underrun_count
- fifo_empty  in  1  FIFO empty flag
- fifo_above_half  in  1  FIFO occupancy ≥ depth/2
- rd_data  in  DATAWIDTH  FIFO read data, valid the cycle after rd_en
- rd_en  out  1  FIFO read strobe, combinational
- sample_out  out  DATAWIDTH  registered sample to interpolation/DAC path
- sample_valid  out  1  one-cycle pulse when sample_out loads new FIFO data
- playing  out  1  registered, 1 while in RUN
- underrun_pulse  out  1  registered one-cycle pulse on underrun detection
- underrun_count  out  CNT_WIDTH  saturating underrun count
- state  out  2  current state (IDLE=0, PREFILL=1, RUN=2, UNDERRUN=3)

## Operation
- Reset values: state IDLE, rd_en 0, sample_out midscale (1<<(DATAWIDTH-1)), sample_valid 0, playing 0, underrun_pulse 0, underrun_count 0. The phase counter and the rd_en delay flop are both 0.
- Phase counter: SAMPLE_RATE bits. It increments only in RUN and wraps from 2^SAMPLE_RATE−1 to 0. It is forced to 0 in every other state and on entry to RUN.
- rd_en = (state==RUN) & (phase==0) & ~fifo_empty & enable.
- IDLE: enable=1 -> PREFILL.
- PREFILL: fifo_above_half=1 -> RUN. Otherwise stay.
- RUN: when phase==0 and fifo_empty=1 -> UNDERRUN. The same edge sets underrun_pulse=1 and increments underrun_count (saturates at all-ones). No read is issued.
- UNDERRUN: sample_out holds its last value. fifo_above_half=1 -> RUN with phase 0.
- enable=0 in any non-IDLE state -> IDLE on the next edge. This has priority over all other transitions. sample_out loads midscale on that edge.
- Capture: rd_en_d <= rd_en. When rd_en_d=1 and enable=1, sample_out <= rd_data and sample_valid=1 for one cycle. When rd_en_d=1 and enable=0, the read data is discarded, sample_out goes to midscale and sample_valid stays 0.
- clr_count=1 clears underrun_count to 0 on the next edge. If an underrun occurs on the same edge, the clear wins (result 0) but underrun_pulse still fires.
- fifo_empty is sampled only at phase==0. Emptiness at other phases has no effect.

## Timing
- rd_en to sample_out/sample_valid: 1 clock.
- Steady state: one rd_en, then one sample_valid, every 2^SAMPLE_RATE clocks. No back-to-back reads.
- First read: PREFILL→RUN edge. rd_en is asserted in the first RUN cycle (phase 0) if the FIFO is not empty.
- Underrun detection to underrun_pulse: asserted the cycle after the phase-0 cycle that saw empty (registered with the state change).
- UNDERRUN→RUN: the first read is issued in the first RUN cycle, so samples resume at phase 0 with no partial period.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously). Any in-flight read is lost.
- playing mirrors state==RUN, registered on the same edge as the state change.

## Test plan
- Reset, then enable=1 with fifo_above_half=0 for 10 cycles -> state=1, rd_en=0, sample_out=0x2000. Raise fifo_above_half -> state=2, and rd_en=1 in the first RUN cycle.
- RUN with SAMPLE_RATE=4, FIFO holding 0x0001..0x0008 -> rd_en every 16 clocks. sample_out steps 0x0001..0x0008 one cycle after each rd_en, each with a one-cycle sample_valid.
- fifo_empty=1 at phase 0 after sample 0x0123 -> state=3, underrun_pulse for 1 cycle, underrun_count=1, sample_out holds 0x0123. Assert fifo_above_half -> RUN, and reading resumes at phase 0.
- Drop enable in the cycle that rd_en=1 -> next edge state=0, sample_valid stays 0, sample_out=0x2000.
- Force 300 underruns with CNT_WIDTH=8 -> underrun_count saturates at 0xFF. clr_count coincident with an underrun -> count=0, underrun_pulse=1.
- Assert rst_in asynchronously mid-period in RUN -> all outputs reach reset values before the next clock edge. After release, the block sits in IDLE until enable.
